ts_bus_master: RTL and testbench
================================

// Module: ts_bus_master
// PURPOSE
// Bus initiator for the Turbosound-FM AY-style port. It turns one-word host commands into
// timed BDIR/BC/DO bus phases: chip-select byte, address latch, data write and register read.
// It sits between a sequencer or CPU-side command source and the Turbosound block.
// Its phases are long enough for the Turbosound's 2-flop input sync and BDIR edge detect.
// It caches the last select byte sent and skips the select phase when nothing has changed.
// PARAMETERS
// PULSE_CLKS  4  CLK cycles BDIR is held high per write phase (legal >=2)
// GAP_CLKS    2  idle CLK cycles after each phase, BDIR=0 BC=0 DO=0 (legal >=1)
// READ_CLKS   6  CLK cycles BDIR=0 BC=1 during a read phase; DI sampled in the last one (legal >=4)
// PORTS
// CLK        in   1  clock
// RESET_s    in   1  reset, asynchronous, active-high
// cmd_valid  in   1  command offered
// cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
// cmd_op     in   2  0=SELECT only, 1=WRITE addr+data, 2=READ addr then read, 3=ADDR latch only
// cmd_chip   in   1  chip select bit (select byte bit0)
// cmd_stat   in   1  status-read select (select byte bit1)
// cmd_fm_en  in   1  FM enable; sent inverted as select byte bit2
// cmd_addr   in   8  register address
// cmd_data   in   8  write data
// rd_valid   out  1  one-cycle pulse: rd_data valid
// rd_data    out  8  captured read data
// err        out  1  one-cycle pulse: command rejected
// busy       out  1  command in progress
// BDIR       out  1  bus direction to Turbosound
// BC         out  1  bus control to Turbosound
// DO         out  8  bus data to Turbosound DI
// DI         in   8  Turbosound DO
// BEHAVIOUR
// - Reset (async): BDIR=0 BC=0 DO=0 rd_valid=0 rd_data=0 err=0 busy=0; FSM->IDLE.
//   Pending command dropped; cache={chip=1,stat=1,fm_en=0}, matching Turbosound reset state.
// - cmd_ready = ~busy. On accept, all cmd_* fields are registered. busy=1 from the next cycle
//   through the final GAP cycle; a new command can be accepted the cycle after busy falls.
// - Select byte SB = {5'b11111, ~cmd_fm_en, cmd_stat, cmd_chip}.
//   SEL phase is emitted if op==0 or {chip,stat,fm_en} != cache; cache updated at SEL HOLD.
// - Address guard: cmd_addr[7:3]==5'b11111 with op!=0 would decode as a select byte.
//   Such a command is accepted, err pulses the cycle after accept, there is no bus activity, busy stays 0.
// - Write phase (SEL: BC=1 DO=SB; ADDR: BC=1 DO=addr; DATA: BC=0 DO=data):
//   SETUP 1 clk: BDIR=0, BC/DO driven.
//   PULSE PULSE_CLKS: BDIR=1, BC/DO held.
//   HOLD 1 clk: BDIR=0, BC/DO held.
//   GAP GAP_CLKS: BDIR=0 BC=0 DO=0.
// - Read phase: BDIR=0 BC=1 DO=0 for READ_CLKS clocks; rd_data<=DI in the last cycle.
//   rd_valid pulses the following cycle, then GAP.
// - FSM: IDLE->(SEL?)->ADDR->{DATA | READ | done}; op0: IDLE->SEL->done.
//   Each phase steps SETUP->PULSE->HOLD->GAP; done->IDLE with busy=0.
// - Phase length Tw = PULSE_CLKS+GAP_CLKS+2; defaults Tw=8.
//   Default read phase = READ_CLKS+GAP_CLKS = 8 cycles.
// - BDIR and BC are never both changed in the same cycle BDIR rises or falls.
//   DO is stable from SETUP through HOLD.
// - A phase counter of width clog2(max param)+1 is reloaded at each state entry; it does not wrap.
// TESTING
// - Reset then WRITE chip=1 stat=1 fm_en=0 addr=07 data=3F: no SEL, ADDR then DATA.
//   BDIR high 4 clks each; busy for 16 clks; Turbosound reg7=3F.
// - WRITE chip=0 addr=08 data=0F: SEL DO=FE first, then ADDR 08, DATA 0F (24 clks).
//   Repeat the same chip: no SEL (16 clks).
// - READ chip=0 addr=08 after the previous write: rd_valid pulse with rd_data=0F.
//   BDIR stays 0 during the read phase.
// - WRITE addr=FA: err pulse, BDIR never rises, busy=0, cmd_ready stays 1.
// - Assert RESET_s during a PULSE: BDIR/BC/DO=0 in the same cycle, no rd_valid.
//   The next WRITE chip=1 emits no SEL.
// - Back-to-back cmd_valid held high: second accept occurs exactly 1 clk after busy falls.
//   Ensure GAP_CLKS low time is observed between commands.

Source files
------------

// File: rtl/ts_bus_master.sv
// ts_bus_master: turns one-word host commands into timed BDIR/BC/DO phases for the Turbosound-FM port
module ts_bus_master #(
    parameter int PULSE_CLKS = 4,
    parameter int GAP_CLKS   = 2,
    parameter int READ_CLKS  = 6
) (
    input  logic       CLK,
    input  logic       RESET_s,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic       cmd_chip,
    input  logic       cmd_stat,
    input  logic       cmd_fm_en,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       err,
    output logic       busy,
    output logic       BDIR,
    output logic       BC,
    output logic [7:0] DO,
    input  logic [7:0] DI
);
    localparam int MPG = (PULSE_CLKS > GAP_CLKS) ? PULSE_CLKS : GAP_CLKS;
    localparam int MAXC = (MPG > READ_CLKS) ? MPG : READ_CLKS;
    localparam int CW = $clog2(MAXC) + 1;
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_GAP, S_READ} state_t;
    typedef enum logic [1:0] {P_SEL, P_ADDR, P_DATA, P_READ} phase_t;
    state_t        r_st, w_st;
    phase_t        r_ph, w_ph;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [1:0]    r_op;
    logic          r_chip, r_stat, r_fm;
    logic [7:0]    r_addr, r_data;
    logic [2:0]    r_cache;
    logic          r_err, r_rdv;
    logic [7:0]    r_rd;
    logic          w_acc, w_bad, w_sel, w_last, w_drv, w_cap;
    logic [7:0]    w_sb;
    assign w_acc  = cmd_valid & cmd_ready;
    // addresses 0xF8..0xFF would be decoded by the Turbosound as a select byte
    assign w_bad  = (cmd_op != 2'd0) & (cmd_addr[7:3] == 5'b11111);
    assign w_sel  = (cmd_op == 2'd0) | ({cmd_chip, cmd_stat, cmd_fm_en} != r_cache);
    assign w_last = r_cnt == '0;
    assign w_cap  = (r_st == S_READ) & w_last;
    assign w_drv  = (r_st == S_SETUP) | (r_st == S_PULSE) | (r_st == S_HOLD);
    assign w_sb   = {5'b11111, ~r_fm, r_stat, r_chip};
    assign busy      = r_st != S_IDLE;
    assign cmd_ready = ~busy;
    assign BDIR      = r_st == S_PULSE;
    assign BC        = (w_drv & (r_ph != P_DATA)) | (r_st == S_READ);
    assign DO        = !w_drv ? 8'h00 : (r_ph == P_SEL) ? w_sb : (r_ph == P_ADDR) ? r_addr : r_data;
    assign rd_valid  = r_rdv;
    assign rd_data   = r_rd;
    assign err       = r_err;
    always_comb begin
        w_st  = r_st;
        w_ph  = r_ph;
        w_cnt = w_last ? r_cnt : r_cnt - 1'b1;
        case (r_st)
            S_IDLE: if (w_acc && !w_bad) begin
                w_st = S_SETUP;
                w_ph = w_sel ? P_SEL : P_ADDR;
            end
            S_SETUP: begin
                w_st  = S_PULSE;
                w_cnt = CW'(PULSE_CLKS - 1);
            end
            S_PULSE: w_st = w_last ? S_HOLD : S_PULSE;
            S_HOLD: begin
                w_st  = S_GAP;
                w_cnt = CW'(GAP_CLKS - 1);
            end
            S_READ: if (w_last) begin
                w_st  = S_GAP;
                w_cnt = CW'(GAP_CLKS - 1);
            end
            S_GAP: if (w_last) begin
                w_st = S_IDLE;
                if (r_ph == P_SEL && r_op != 2'd0) begin
                    w_st = S_SETUP;
                    w_ph = P_ADDR;
                end else if (r_ph == P_ADDR && r_op == 2'd1) begin
                    w_st = S_SETUP;
                    w_ph = P_DATA;
                end else if (r_ph == P_ADDR && r_op == 2'd2) begin
                    w_st  = S_READ;
                    w_ph  = P_READ;
                    w_cnt = CW'(READ_CLKS - 1);
                end
            end
            default: w_st = S_IDLE;
        endcase
    end
    always_ff @(posedge CLK or posedge RESET_s) begin
        if (RESET_s) begin
            r_st    <= S_IDLE;
            r_ph    <= P_SEL;
            r_cnt   <= '0;
            r_op    <= '0;
            r_chip  <= 1'b0;
            r_stat  <= 1'b0;
            r_fm    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_cache <= 3'b110;
            r_err   <= 1'b0;
            r_rdv   <= 1'b0;
            r_rd    <= '0;
        end else begin
            r_st  <= w_st;
            r_ph  <= w_ph;
            r_cnt <= w_cnt;
            if (w_acc) begin
                r_op   <= cmd_op;
                r_chip <= cmd_chip;
                r_stat <= cmd_stat;
                r_fm   <= cmd_fm_en;
                r_addr <= cmd_addr;
                r_data <= cmd_data;
            end
            r_err <= w_acc & w_bad;
            r_rdv <= w_cap;
            if (w_cap) r_rd <= DI;
            if (r_st == S_HOLD && r_ph == P_SEL) r_cache <= {r_chip, r_stat, r_fm};
        end
    end
endmodule

// File: tb/tb_ts_bus_master.sv
// tb_ts_bus_master: directed and random commands checked against a command-level model and a Turbosound stub
module tb_ts_bus_master;
    localparam int PC = 4;
    localparam int GC = 2;
    localparam int RC = 6;
    logic       CLK = 1'b0;
    logic       RESET_s = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = '0;
    logic       cmd_chip = 1'b0, cmd_stat = 1'b0, cmd_fm_en = 1'b0;
    logic [7:0] cmd_addr = '0, cmd_data = '0;
    logic       rd_valid, err, busy, BDIR, BC;
    logic [7:0] rd_data, DO, DI;
    int n_vec = 0;
    int n_err = 0;
    logic [7:0] mreg [2][256];
    logic [2:0] m_cache;
    logic [7:0] ts_reg [2][256];
    logic       ts_chip;
    logic [7:0] ts_addr;
    logic [8:0] bus_q[$];
    logic       p_bdir, p_bc;
    logic [7:0] p_do;
    int         hi, lo, rdv_n;
    logic [7:0] rdv_d;
    logic [1:0] rop;
    logic       rc, rs, rf;
    logic [7:0] ra, rdt;
    int         nb, rb;

    ts_bus_master #(.PULSE_CLKS(PC), .GAP_CLKS(GC), .READ_CLKS(RC)) dut (
        .CLK(CLK), .RESET_s(RESET_s), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_chip(cmd_chip), .cmd_stat(cmd_stat), .cmd_fm_en(cmd_fm_en),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .rd_valid(rd_valid), .rd_data(rd_data),
        .err(err), .busy(busy), .BDIR(BDIR), .BC(BC), .DO(DO), .DI(DI)
    );

    always #5 CLK = ~CLK;
    assign DI = ts_reg[ts_chip][ts_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Turbosound stand-in: latches on each BDIR pulse and checks bus timing rules
    always @(negedge CLK) begin
        if (RESET_s) begin
            p_bdir  <= 1'b0;
            p_bc    <= 1'b0;
            p_do    <= '0;
            hi      <= 0;
            lo      <= 99;
            ts_chip <= 1'b1;
            ts_addr <= '0;
            rdv_n   <= 0;
            rdv_d   <= '0;
            for (int c = 0; c < 2; c++)
                for (int a = 0; a < 256; a++)
                    ts_reg[c][a] <= '0;
        end else begin
            if (BDIR && !p_bdir) begin
                chk("bc_at_rise", BC, p_bc);
                if (lo != 99) chk("low_time_ok", lo >= GC + 2, 1);
            end
            if (BDIR && p_bdir) chk("do_stable", {BC, DO}, {p_bc, p_do});
            if (!BDIR && p_bdir) begin
                chk("bc_at_fall", BC, p_bc);
                chk("pulse_width", hi, PC);
                bus_q.push_back({p_bc, p_do});
                if (p_bc && p_do[7:3] == 5'b11111) ts_chip <= p_do[0];
                else if (p_bc) ts_addr <= p_do;
                else ts_reg[ts_chip][ts_addr] <= p_do;
            end
            hi <= BDIR ? hi + 1 : 0;
            lo <= BDIR ? 0 : (lo < 99 ? lo + 1 : lo);
            if (rd_valid) begin
                rdv_n <= rdv_n + 1;
                rdv_d <= rd_data;
            end
            p_bdir <= BDIR;
            p_bc   <= BC;
            p_do   <= DO;
        end
    end

    task automatic do_reset();
        RESET_s = 1'b1;
        cmd_valid = 1'b0;
        m_cache = 3'b110;
        for (int c = 0; c < 2; c++)
            for (int a = 0; a < 256; a++)
                mreg[c][a] = '0;
        repeat (2) @(negedge CLK);
        RESET_s = 1'b0;
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic c, input logic s, input logic f,
                           input logic [7:0] a, input logic [7:0] d);
        logic bad, sel, rd;
        logic [8:0] eq[$];
        int base, r0, n;
        bad = (op != 2'd0) && (a[7:3] == 5'b11111);
        sel = !bad && (op == 2'd0 || {c, s, f} != m_cache);
        rd  = !bad && op == 2'd2;
        if (sel) eq.push_back({1'b1, 5'b11111, ~f, s, c});
        if (!bad && op != 2'd0) eq.push_back({1'b1, a});
        if (!bad && op == 2'd1) eq.push_back({1'b0, d});
        base = bus_q.size();
        r0 = rdv_n;
        @(negedge CLK);
        chk("ready_before", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op = op; cmd_chip = c; cmd_stat = s; cmd_fm_en = f; cmd_addr = a; cmd_data = d;
        @(negedge CLK);
        cmd_valid = 1'b0;
        chk("err_pulse", err, bad);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge CLK);
        end
        chk("busy_len", n, 8 * eq.size() + (rd ? RC + GC : 0));
        chk("ready_after", cmd_ready, 1);
        chk("bus_count", bus_q.size() - base, eq.size());
        foreach (eq[k])
            if (base + k < bus_q.size()) chk("bus_word", bus_q[base + k], eq[k]);
        chk("rd_pulses", rdv_n - r0, rd);
        if (rd) chk("rd_data", rdv_d, mreg[c][a]);
        if (sel) m_cache = {c, s, f};
        if (!bad && op == 2'd1) mreg[c][a] = d;
    endtask

    initial begin
        do_reset();
        chk("rst_bdir", BDIR, 0);
        chk("rst_bc", BC, 0);
        chk("rst_do", DO, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_rdv", rd_valid, 0);
        chk("rst_rdata", rd_data, 0);
        chk("rst_err", err, 0);
        run_cmd(2'd1, 1'b1, 1'b1, 1'b0, 8'h07, 8'h3F);
        run_cmd(2'd1, 1'b0, 1'b1, 1'b0, 8'h08, 8'h0F);
        run_cmd(2'd1, 1'b0, 1'b1, 1'b0, 8'h08, 8'h0F);
        run_cmd(2'd2, 1'b0, 1'b1, 1'b0, 8'h08, 8'h00);
        run_cmd(2'd2, 1'b1, 1'b1, 1'b0, 8'h07, 8'h00);
        run_cmd(2'd1, 1'b1, 1'b1, 1'b0, 8'hFA, 8'h12);
        run_cmd(2'd0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        // reset while a READ is mid-pulse
        @(negedge CLK);
        cmd_valid = 1'b1;
        cmd_op = 2'd2; cmd_chip = 1'b0; cmd_stat = 1'b1; cmd_fm_en = 1'b0; cmd_addr = 8'h08;
        @(negedge CLK);
        cmd_valid = 1'b0;
        nb = 0;
        while (BDIR !== 1'b1 && nb < 50) begin
            nb++;
            @(negedge CLK);
        end
        chk("bdir_rose", BDIR, 1);
        @(posedge CLK);
        #1 RESET_s = 1'b1;
        #1;
        chk("midrst_bdir", BDIR, 0);
        chk("midrst_bc", BC, 0);
        chk("midrst_do", DO, 0);
        chk("midrst_busy", busy, 0);
        do_reset();
        rb = rdv_n;
        repeat (12) @(negedge CLK);
        chk("midrst_no_rdv", rdv_n - rb, 0);
        run_cmd(2'd1, 1'b1, 1'b1, 1'b0, 8'h03, 8'hA5);
        run_cmd(2'd2, 1'b1, 1'b1, 1'b0, 8'h07, 8'h00);
        // back-to-back: cmd_valid held high across two writes
        @(negedge CLK);
        cmd_valid = 1'b1;
        cmd_op = 2'd1; cmd_chip = 1'b1; cmd_stat = 1'b1; cmd_fm_en = 1'b0;
        cmd_addr = 8'h05; cmd_data = 8'h55;
        @(negedge CLK);
        cmd_addr = 8'h06; cmd_data = 8'h66;
        nb = 0;
        while (busy === 1'b1 && nb < 200) begin
            nb++;
            @(negedge CLK);
        end
        chk("b2b_first_len", nb, 16);
        chk("b2b_ready", cmd_ready, 1);
        @(negedge CLK);
        chk("b2b_accept", busy, 1);
        cmd_valid = 1'b0;
        nb = 1;
        while (busy === 1'b1 && nb < 200) begin
            nb++;
            @(negedge CLK);
        end
        chk("b2b_second_len", nb, 17);
        mreg[1][8'h05] = 8'h55;
        mreg[1][8'h06] = 8'h66;
        run_cmd(2'd2, 1'b1, 1'b1, 1'b0, 8'h06, 8'h00);
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            rc  = 1'($urandom_range(0, 1));
            rs  = $urandom_range(0, 3) != 0;
            rf  = $urandom_range(0, 3) == 0;
            ra  = 8'($urandom_range(0, 15));
            rdt = 8'($urandom_range(0, 255));
            if (i % 8 == 3) ra = 8'hF8 | 8'($urandom_range(0, 7));
            run_cmd(rop, rc, rs, rf, ra, rdt);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
